wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 118 +++++++++++
 tb/tb_wb_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: pending register-file write queue.
// A circular FIFO of {sel, data} writes that drains into a registered
// write port (wen/selRd/rd) whenever stall is low. Two combinational
// lookups (Rs, Rt) report the youngest pending write to a register, so a
// reader can forward data that has not reached the register file yet.
//
// Handshake: a request transfers on a rising edge where inValid and inReady
// are both high. inReady does not depend on inValid. When the queue is full,
// inReady is still high if an entry drains at the same edge, so a full queue
// can accept a write while it drains and keep its count.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [3:0]               inSel,
    input  logic [15:0]              inData,
    input  logic                     stall,
    output logic                     wen,
    output logic [3:0]               selRd,
    output logic [15:0]              rd,
    input  logic [3:0]               selRs,
    input  logic [3:0]               selRt,
    output logic                     hitRs,
    output logic                     hitRt,
    output logic [15:0]              fwdRs,
    output logic [15:0]              fwdRt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [3:0]    memSel  [DEPTH];
    logic [15:0]   memData [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;

    // Drain whenever something is queued and the consumer is not stalled.
    assign pop     = (count != '0) && !stall;
    assign inReady = (count != FULL) || pop;
    assign push    = inValid && inReady;
    assign empty   = (count == '0);

    // Entry storage; contents are only observable through valid slots.
    always_ff @(posedge clk) begin
        if (push) begin
            memSel[tail]  <= inSel;
            memData[tail] <= inData;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            wen   <= 1'b0;
            selRd <= '0;
            rd    <= '0;
        end else begin
            wen <= pop;
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head  <= head + PW'(1);
                selRd <= memSel[head];
                rd    <= memData[head];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Hazard lookup: scan oldest to youngest so the youngest match wins;
    // the output stage is older than every queued entry, so it goes first.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        hitRs = 1'b0;
        fwdRs = '0;
        hitRt = 1'b0;
        fwdRt = '0;
        if (wen && (selRd == selRs)) begin
            hitRs = 1'b1;
            fwdRs = rd;
        end
        if (wen && (selRd == selRt)) begin
            hitRt = 1'b1;
            fwdRt = rd;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (memSel[idx] == selRs) begin
                    hitRs = 1'b1;
                    fwdRs = memData[idx];
                end
                if (memSel[idx] == selRt) begin
                    hitRt = 1'b1;
                    fwdRt = memData[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model of wb_queue.
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inSel;
    logic [15:0] inData;
    logic        stall;
    logic        wen;
    logic [3:0]  selRd;
    logic [15:0] rd;
    logic [3:0]  selRs;
    logic [3:0]  selRt;
    logic        hitRs;
    logic        hitRt;
    logic [15:0] fwdRs;
    logic [15:0] fwdRt;
    logic [2:0]  count;
    logic        empty;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inReady(inReady), .inSel(inSel), .inData(inData),
        .stall(stall),
        .wen(wen), .selRd(selRd), .rd(rd),
        .selRs(selRs), .selRt(selRt),
        .hitRs(hitRs), .hitRt(hitRt), .fwdRs(fwdRs), .fwdRt(fwdRt),
        .count(count), .empty(empty)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending writes as a queue of {sel, data}, plus the
    // last committed write.
    logic [19:0] expQ[$];
    logic        mWen;
    logic [3:0]  mSel;
    logic [15:0] mRd;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic        v;
        logic [3:0]  sel;
        logic [15:0] data;
        logic        st;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic        eWen;
        logic [3:0]  eSelRd;
        logic [15:0] eRd;
        logic [2:0]  eCount;
        logic        eReady;
        logic        eHitRs;
        logic [15:0] eFwdRs;
        logic        eHitRt;
        logic [15:0] eFwdRt;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic [15:0] d,
                         input logic st, input logic [3:0] rs, input logic [3:0] rt);
        inValid = v;
        inSel   = s;
        inData  = d;
        stall   = st;
        selRs   = rs;
        selRt   = rt;
    endtask

    task automatic modelClear();
        expQ.delete();
        mWen = 1'b0;
        mSel = '0;
        mRd  = '0;
    endtask

    // Youngest pending write first, then the committed write.
    task automatic lookup(input logic [3:0] s, output logic h, output logic [15:0] f);
        h = 1'b0;
        f = '0;
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (!h && expQ[i][19:16] == s) begin
                h = 1'b1;
                f = expQ[i][15:0];
            end
        end
        if (!h && mWen && mSel == s) begin
            h = 1'b1;
            f = mRd;
        end
    endtask

    function automatic logic modelReady();
        return (expQ.size() < DEPTH) || (expQ.size() != 0 && !stall);
    endfunction

    // Apply the edge rules to the model using the inputs currently driven.
    task automatic modelStep();
        logic        doPop;
        logic        doPush;
        logic [19:0] e;
        doPop  = (expQ.size() != 0) && !stall;
        doPush = inValid && modelReady();
        if (doPop) begin
            e    = expQ.pop_front();
            mWen = 1'b1;
            mSel = e[19:16];
            mRd  = e[15:0];
        end else begin
            mWen = 1'b0;
        end
        if (doPush) expQ.push_back({inSel, inData});
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        logic        h;
        logic [15:0] f;
        chk({tag, ".count"}, 32'(count), 32'(expQ.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(expQ.size() == 0));
        chk({tag, ".inReady"}, 32'(inReady), 32'(modelReady()));
        chk({tag, ".wen"}, 32'(wen), 32'(mWen));
        chk({tag, ".selRd"}, 32'(selRd), 32'(mSel));
        chk({tag, ".rd"}, 32'(rd), 32'(mRd));
        lookup(selRs, h, f);
        chk({tag, ".hitRs"}, 32'(hitRs), 32'(h));
        chk({tag, ".fwdRs"}, 32'(fwdRs), 32'(f));
        lookup(selRt, h, f);
        chk({tag, ".hitRt"}, 32'(hitRt), 32'(h));
        chk({tag, ".fwdRt"}, 32'(fwdRt), 32'(f));
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, ".count"}, 32'(count), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".inReady"}, 32'(inReady), 1);
        chk({tag, ".wen"}, 32'(wen), 0);
        chk({tag, ".selRd"}, 32'(selRd), 0);
        chk({tag, ".rd"}, 32'(rd), 0);
        chk({tag, ".hitRs"}, 32'(hitRs), 0);
        chk({tag, ".fwdRs"}, 32'(fwdRs), 0);
        chk({tag, ".hitRt"}, 32'(hitRt), 0);
        chk({tag, ".fwdRt"}, 32'(fwdRt), 0);
    endtask

    // Reset pulse placed between edges; called just after a rising edge.
    task automatic midReset(input string tag);
        rst = 1'b0;
        #1;
        checkResetState(tag);
        #1;
        rst = 1'b1;
        modelClear();
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset block
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b1;

        // Directed vectors: single write, forwarding priority, output-stage
        // forwarding, register 0, and hold of the write port.
        //          v  sel    data      st rs    rt  | wen selRd rd    cnt rdy hRs fRs     hRt fRt
        tbl[0]  = '{1, 4'd5, 16'hBEEF, 0, 4'd5, 4'd0, 0, 4'd0, 16'h0000, 3'd0, 1, 0, 16'h0000, 0, 16'h0000};
        tbl[1]  = '{0, 4'd0, 16'h0000, 0, 4'd5, 4'd5, 0, 4'd0, 16'h0000, 3'd1, 1, 1, 16'hBEEF, 1, 16'hBEEF};
        tbl[2]  = '{0, 4'd0, 16'h0000, 0, 4'd5, 4'd6, 1, 4'd5, 16'hBEEF, 3'd0, 1, 1, 16'hBEEF, 0, 16'h0000};
        tbl[3]  = '{1, 4'd3, 16'h1111, 1, 4'd3, 4'd4, 0, 4'd5, 16'hBEEF, 3'd0, 1, 0, 16'h0000, 0, 16'h0000};
        tbl[4]  = '{1, 4'd3, 16'h2222, 1, 4'd3, 4'd4, 0, 4'd5, 16'hBEEF, 3'd1, 1, 1, 16'h1111, 0, 16'h0000};
        tbl[5]  = '{0, 4'd0, 16'h0000, 1, 4'd3, 4'd4, 0, 4'd5, 16'hBEEF, 3'd2, 1, 1, 16'h2222, 0, 16'h0000};
        tbl[6]  = '{0, 4'd0, 16'h0000, 0, 4'd3, 4'd3, 0, 4'd5, 16'hBEEF, 3'd2, 1, 1, 16'h2222, 1, 16'h2222};
        tbl[7]  = '{1, 4'd7, 16'hAAAA, 1, 4'd3, 4'd7, 1, 4'd3, 16'h1111, 3'd1, 1, 1, 16'h2222, 0, 16'h0000};
        tbl[8]  = '{0, 4'd0, 16'h0000, 0, 4'd3, 4'd7, 0, 4'd3, 16'h1111, 3'd2, 1, 1, 16'h2222, 1, 16'hAAAA};
        tbl[9]  = '{0, 4'd0, 16'h0000, 0, 4'd3, 4'd7, 1, 4'd3, 16'h2222, 3'd1, 1, 1, 16'h2222, 1, 16'hAAAA};
        tbl[10] = '{0, 4'd0, 16'h0000, 1, 4'd3, 4'd7, 1, 4'd7, 16'hAAAA, 3'd0, 1, 0, 16'h0000, 1, 16'hAAAA};
        tbl[11] = '{1, 4'd0, 16'h00FF, 0, 4'd0, 4'd7, 0, 4'd7, 16'hAAAA, 3'd0, 1, 0, 16'h0000, 0, 16'h0000};
        tbl[12] = '{0, 4'd0, 16'h0000, 1, 4'd0, 4'd0, 0, 4'd7, 16'hAAAA, 3'd1, 1, 1, 16'h00FF, 1, 16'h00FF};
        tbl[13] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd1, 0, 4'd7, 16'hAAAA, 3'd1, 1, 1, 16'h00FF, 0, 16'h0000};
        tbl[14] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd1, 1, 4'd0, 16'h00FF, 3'd0, 1, 1, 16'h00FF, 0, 16'h0000};
        tbl[15] = '{0, 4'd0, 16'h0000, 0, 4'd0, 4'd1, 0, 4'd0, 16'h00FF, 3'd0, 1, 0, 16'h0000, 0, 16'h0000};

        for (int i = 0; i < 16; i++) begin
            string t;
            t = $sformatf("row%0d", i);
            drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].st, tbl[i].rs, tbl[i].rt);
            @(negedge clk);
            chk({t, ".wen"}, 32'(wen), 32'(tbl[i].eWen));
            chk({t, ".selRd"}, 32'(selRd), 32'(tbl[i].eSelRd));
            chk({t, ".rd"}, 32'(rd), 32'(tbl[i].eRd));
            chk({t, ".count"}, 32'(count), 32'(tbl[i].eCount));
            chk({t, ".empty"}, 32'(empty), 32'(tbl[i].eCount == 0));
            chk({t, ".inReady"}, 32'(inReady), 32'(tbl[i].eReady));
            chk({t, ".hitRs"}, 32'(hitRs), 32'(tbl[i].eHitRs));
            chk({t, ".fwdRs"}, 32'(fwdRs), 32'(tbl[i].eFwdRs));
            chk({t, ".hitRt"}, 32'(hitRt), 32'(tbl[i].eHitRt));
            chk({t, ".fwdRt"}, 32'(fwdRt), 32'(tbl[i].eFwdRt));
            tick();
        end

        // Fill under stall, then drain in order on consecutive cycles.
        drive(0, 0, 0, 1, 0, 0);
        midReset("fillReset");
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'(i), 16'(i), 1, 4'(i), 0);
            @(negedge clk);
            checkModel($sformatf("fill%0d", i));
            tick();
        end
        drive(1, 4'd8, 16'h0008, 1, 4'd4, 4'd1);
        @(negedge clk);
        chk("full.count", 32'(count), 4);
        chk("full.inReady", 32'(inReady), 0);
        checkModel("full");
        tick();
        for (int k = 0; k <= 4; k++) begin
            drive(0, 0, 0, 0, 4'd4, 4'd1);
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("drain%0d.wen", k), 32'(wen), 1);
                chk($sformatf("drain%0d.selRd", k), 32'(selRd), k);
                chk($sformatf("drain%0d.rd", k), 32'(rd), k);
            end
            checkModel($sformatf("drain%0d", k));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("drainEnd.wen", 32'(wen), 0);
        chk("drainEnd.count", 32'(count), 0);
        tick();

        // Full queue accepts a push while draining.
        midReset("fullPushReset");
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'(i), 16'(i), 1, 0, 0);
            tick();
        end
        drive(1, 4'd9, 16'h0909, 0, 4'd9, 4'd2);
        @(negedge clk);
        chk("fullPush.inReady", 32'(inReady), 1);
        checkModel("fullPush");
        tick();
        begin
            logic [3:0]  order[5];
            logic [15:0] odata[5];
            order = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9};
            odata = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0909};
            for (int k = 0; k < 5; k++) begin
                drive(0, 0, 0, 0, 4'd9, 4'd2);
                @(negedge clk);
                if (k == 0) chk("fullPush.countAfter", 32'(count), 4);
                chk($sformatf("fullOrder%0d.wen", k), 32'(wen), 1);
                chk($sformatf("fullOrder%0d.selRd", k), 32'(selRd), 32'(order[k]));
                chk($sformatf("fullOrder%0d.rd", k), 32'(rd), 32'(odata[k]));
                checkModel($sformatf("fullOrder%0d", k));
                tick();
            end
        end

        // Mid-stream reset with three entries queued: nothing commits after.
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(10 + i), 16'hC000 + 16'(i), 1, 4'd10, 4'd12);
            tick();
        end
        drive(0, 0, 0, 1, 4'd10, 4'd12);
        @(negedge clk);
        chk("preReset.count", 32'(count), 3);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 4'd10, 4'd12);
        midReset("midReset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("postReset%0d.wen", k), 32'(wen), 0);
            checkModel($sformatf("postReset%0d", k));
            tick();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 7)),
                  16'($urandom),
                  1'($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)));
            @(negedge clk);
            checkModel($sformatf("rand%0d", n));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
